// File: rtl/qerv_rf_pkg.sv
// Shared definitions for the qerv serial register-file port: FSM states,
// register address width and beat count derivation.
package qerv_rf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RREQ,
        S_RWAIT,
        S_RSHIFT,
        S_WREQ,
        S_WSHIFT,
        S_RSP
    } rf_state_e;

    // 32 GPRs followed by the CSR block share one address space.
    function automatic int rf_raw_width(input int csr_regs);
        return $clog2(32 + csr_regs);
    endfunction

    function automatic int rf_beats(input int bits_per_cycle);
        return 32 / bits_per_cycle;
    endfunction

endpackage

// File: rtl/qerv_rf_shreg.sv
// 32-bit shift register with parallel load/read; shifts right, taking a
// BITS_PER_CYCLE-wide serial input into the MSB end.
module qerv_rf_shreg #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      i_clk,
    input  logic                      i_load,
    input  logic [31:0]               i_load_data,
    input  logic                      i_shift,
    input  logic [BITS_PER_CYCLE-1:0] i_sin,
    output logic [31:0]               o_q
);

    always_ff @(posedge i_clk) begin
        if (i_load)
            o_q <= i_load_data;
        else if (i_shift)
            o_q <= {i_sin, o_q[31:BITS_PER_CYCLE]};
    end

endmodule

// File: rtl/qerv_rf_host.sv
// Parallel-to-serial initiator for the qerv serial register-file port.
// Accepts whole-register read/write commands and streams them LSB first.
module qerv_rf_host
    import qerv_rf_pkg::*;
#(
    parameter int  BITS_PER_CYCLE = 1,
    parameter int  csr_regs       = 4,
    localparam int raw            = rf_raw_width(csr_regs),
    localparam int BEATS          = rf_beats(BITS_PER_CYCLE)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [raw-1:0]            i_cmd_reg0,
    input  logic [raw-1:0]            i_cmd_reg1,
    input  logic                      i_cmd_wen0,
    input  logic                      i_cmd_wen1,
    input  logic [31:0]               i_cmd_wdata0,
    input  logic [31:0]               i_cmd_wdata1,
    output logic                      o_rsp_valid,
    output logic [31:0]               o_rsp_rdata0,
    output logic [31:0]               o_rsp_rdata1,
    output logic                      o_rreq,
    output logic                      o_wreq,
    input  logic                      i_ready,
    output logic [raw-1:0]            o_rreg0,
    output logic [raw-1:0]            o_rreg1,
    output logic [raw-1:0]            o_wreg0,
    output logic [raw-1:0]            o_wreg1,
    output logic                      o_wen0,
    output logic                      o_wen1,
    output logic [BITS_PER_CYCLE-1:0] o_wdata0,
    output logic [BITS_PER_CYCLE-1:0] o_wdata1,
    input  logic [BITS_PER_CYCLE-1:0] i_rdata0,
    input  logic [BITS_PER_CYCLE-1:0] i_rdata1
);

    localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

    rf_state_e      state_q, state_d;
    logic [4:0]     beat_q;
    logic [raw-1:0] reg0_q, reg1_q;
    logic           wen0_q, wen1_q;
    logic [31:0]    rd_q0, rd_q1, wr_q0, wr_q1;
    logic           accept, beat_last, rd_shift, wr_shift, start_beats;
    logic           write_phase;

    assign accept      = (state_q == S_IDLE) && i_cmd_valid;
    assign beat_last   = (beat_q == LAST_BEAT);
    assign rd_shift    = (state_q == S_RSHIFT);
    assign wr_shift    = (state_q == S_WSHIFT);
    assign write_phase = (state_q == S_WREQ) || wr_shift;
    assign start_beats = ((state_q == S_RWAIT) || (state_q == S_WREQ)) && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        o_cmd_ready = 1'b0;
        o_rreq      = 1'b0;
        o_wreq      = 1'b0;
        o_rsp_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid)
                    state_d = i_cmd_write ? S_WREQ : S_RREQ;
            end
            S_RREQ: begin
                o_rreq  = 1'b1;
                state_d = S_RWAIT;
            end
            S_RWAIT:  if (i_ready) state_d = S_RSHIFT;
            S_RSHIFT: if (beat_last) state_d = S_RSP;
            // Ready is expected on the request cycle, but keep requesting until seen.
            S_WREQ: begin
                o_wreq = 1'b1;
                if (i_ready)
                    state_d = S_WSHIFT;
            end
            S_WSHIFT: if (beat_last) state_d = S_RSP;
            S_RSP: begin
                o_rsp_valid = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            beat_q <= '0;
        else if (start_beats || ((rd_shift || wr_shift) && beat_last))
            beat_q <= '0;
        else if (rd_shift || wr_shift)
            beat_q <= beat_q + 5'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            reg0_q <= '0;
            reg1_q <= '0;
            wen0_q <= 1'b0;
            wen1_q <= 1'b0;
        end else if (accept) begin
            reg0_q <= i_cmd_reg0;
            reg1_q <= i_cmd_reg1;
            wen0_q <= i_cmd_wen0;
            wen1_q <= i_cmd_wen1;
        end
    end

    // The final beat is folded in on the same edge so data lines up with RSP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_rdata0 <= '0;
            o_rsp_rdata1 <= '0;
        end else if (rd_shift && beat_last) begin
            o_rsp_rdata0 <= {i_rdata0, rd_q0[31:BITS_PER_CYCLE]};
            o_rsp_rdata1 <= {i_rdata1, rd_q1[31:BITS_PER_CYCLE]};
        end
    end

    qerv_rf_shreg #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_read0 (
        .i_clk(i_clk), .i_load(1'b0), .i_load_data(32'd0),
        .i_shift(rd_shift), .i_sin(i_rdata0), .o_q(rd_q0)
    );

    qerv_rf_shreg #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_read1 (
        .i_clk(i_clk), .i_load(1'b0), .i_load_data(32'd0),
        .i_shift(rd_shift), .i_sin(i_rdata1), .o_q(rd_q1)
    );

    qerv_rf_shreg #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_write0 (
        .i_clk(i_clk), .i_load(accept), .i_load_data(i_cmd_wdata0),
        .i_shift(wr_shift), .i_sin('0), .o_q(wr_q0)
    );

    qerv_rf_shreg #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_write1 (
        .i_clk(i_clk), .i_load(accept), .i_load_data(i_cmd_wdata1),
        .i_shift(wr_shift), .i_sin('0), .o_q(wr_q1)
    );

    // Bits that are shifted out or dropped and never reach an output.
    logic unused_bits;
    assign unused_bits = ^{rd_q0[BITS_PER_CYCLE-1:0], rd_q1[BITS_PER_CYCLE-1:0],
                           wr_q0[31:BITS_PER_CYCLE], wr_q1[31:BITS_PER_CYCLE]};

    assign o_rreg0  = reg0_q;
    assign o_rreg1  = reg1_q;
    assign o_wreg0  = reg0_q;
    assign o_wreg1  = reg1_q;
    assign o_wen0   = wen0_q && write_phase;
    assign o_wen1   = wen1_q && write_phase;
    assign o_wdata0 = wr_shift ? wr_q0[BITS_PER_CYCLE-1:0] : '0;
    assign o_wdata1 = wr_shift ? wr_q1[BITS_PER_CYCLE-1:0] : '0;

endmodule

// File: tb/tb_qerv_rf_host.sv
// Self-checking bench for qerv_rf_host: table vectors, hand-written corner
// sequences and random commands against a register-file reference model.
module tb_qerv_rf_host;

    localparam int B     = 4;
    localparam int RAW   = 6;
    localparam int BEATS = 32 / B;

    typedef struct {
        logic           write;
        logic [RAW-1:0] reg0;
        logic [RAW-1:0] reg1;
        logic           wen0;
        logic           wen1;
        logic [31:0]    wdata0;
        logic [31:0]    wdata1;
        int             delay;
        logic [31:0]    exp0;
        logic [31:0]    exp1;
    } vec_t;

    logic           clk = 1'b0;
    logic           i_rst, i_cmd_valid, i_cmd_write, i_cmd_wen0, i_cmd_wen1;
    logic [RAW-1:0] i_cmd_reg0, i_cmd_reg1;
    logic [31:0]    i_cmd_wdata0, i_cmd_wdata1;
    logic           o_cmd_ready, o_rsp_valid, o_rreq, o_wreq, o_wen0, o_wen1;
    logic [31:0]    o_rsp_rdata0, o_rsp_rdata1;
    logic [RAW-1:0] o_rreg0, o_rreg1, o_wreg0, o_wreg1;
    logic [B-1:0]   o_wdata0, o_wdata1, i_rdata0, i_rdata1;
    logic           rd_ready, i_ready;

    // Serial side answers a write request combinationally, reads on demand.
    assign i_ready = rd_ready | o_wreq;

    logic [31:0] rf_mem  [64];
    logic [31:0] ref_mem [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qerv_rf_host #(.BITS_PER_CYCLE(B), .csr_regs(4)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_reg0(i_cmd_reg0), .i_cmd_reg1(i_cmd_reg1),
        .i_cmd_wen0(i_cmd_wen0), .i_cmd_wen1(i_cmd_wen1),
        .i_cmd_wdata0(i_cmd_wdata0), .i_cmd_wdata1(i_cmd_wdata1),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata0(o_rsp_rdata0), .o_rsp_rdata1(o_rsp_rdata1),
        .o_rreq(o_rreq), .o_wreq(o_wreq), .i_ready(i_ready),
        .o_rreg0(o_rreg0), .o_rreg1(o_rreg1), .o_wreg0(o_wreg0), .o_wreg1(o_wreg1),
        .o_wen0(o_wen0), .o_wen1(o_wen1), .o_wdata0(o_wdata0), .o_wdata1(o_wdata1),
        .i_rdata0(i_rdata0), .i_rdata1(i_rdata1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkVec(input logic write, input int r0, input int r1,
                                   input logic w0, input logic w1,
                                   input logic [31:0] d0, input logic [31:0] d1,
                                   input int delay,
                                   input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.write = write; v.reg0 = RAW'(r0); v.reg1 = RAW'(r1);
        v.wen0 = w0; v.wen1 = w1; v.wdata0 = d0; v.wdata1 = d1;
        v.delay = delay; v.exp0 = e0; v.exp1 = e1;
        return v;
    endfunction

    task automatic runRead(input vec_t v, input bit hold);
        logic [31:0] word0, word1;
        i_cmd_write = 1'b0; i_cmd_reg0 = v.reg0; i_cmd_reg1 = v.reg1;
        i_cmd_valid = 1'b1;
        checkOutput("idle_ready", 32'(o_cmd_ready), 32'd1);
        step();
        if (!hold) i_cmd_valid = 1'b0;
        checkOutput("rreq_pulse", 32'(o_rreq), 32'd1);
        checkOutput("busy_rreq", 32'(o_cmd_ready), 32'd0);
        step();
        for (int c = 0; c < v.delay; c++) begin
            i_rdata0 = B'($urandom);
            i_rdata1 = B'($urandom);
            checkOutput("rreq_once", 32'(o_rreq), 32'd0);
            checkOutput("no_rsp_stall", 32'(o_rsp_valid), 32'd0);
            step();
        end
        rd_ready = 1'b1;
        checkOutput("rreq_once", 32'(o_rreq), 32'd0);
        checkOutput("rd_wen0_off", 32'(o_wen0), 32'd0);
        step();
        rd_ready = 1'b0;
        word0 = rf_mem[v.reg0];
        word1 = rf_mem[v.reg1];
        for (int k = 0; k < BEATS; k++) begin
            i_rdata0 = word0[k*B +: B];
            i_rdata1 = word1[k*B +: B];
            checkOutput("rreg0_held", 32'(o_rreg0), 32'(v.reg0));
            checkOutput("rreg1_held", 32'(o_rreg1), 32'(v.reg1));
            checkOutput("busy_rshift", 32'(o_cmd_ready), 32'd0);
            checkOutput("no_rsp_early", 32'(o_rsp_valid), 32'd0);
            step();
        end
        checkOutput("rd_rsp_valid", 32'(o_rsp_valid), 32'd1);
        checkOutput("rdata0", o_rsp_rdata0, v.exp0);
        checkOutput("rdata1", o_rsp_rdata1, v.exp1);
        step();
        checkOutput("rd_rsp_end", 32'(o_rsp_valid), 32'd0);
        checkOutput("rd_ready_after", 32'(o_cmd_ready), 32'd1);
        checkOutput("rdata0_held", o_rsp_rdata0, v.exp0);
    endtask

    task automatic runWrite(input vec_t v, input bit hold);
        logic [31:0] cap0, cap1;
        i_cmd_write = 1'b1; i_cmd_reg0 = v.reg0; i_cmd_reg1 = v.reg1;
        i_cmd_wen0 = v.wen0; i_cmd_wen1 = v.wen1;
        i_cmd_wdata0 = v.wdata0; i_cmd_wdata1 = v.wdata1;
        i_cmd_valid = 1'b1;
        checkOutput("idle_ready", 32'(o_cmd_ready), 32'd1);
        step();
        if (!hold) i_cmd_valid = 1'b0;
        checkOutput("wreq_pulse", 32'(o_wreq), 32'd1);
        checkOutput("wreg0", 32'(o_wreg0), 32'(v.reg0));
        checkOutput("wreg1", 32'(o_wreg1), 32'(v.reg1));
        checkOutput("wen0_req", 32'(o_wen0), 32'(v.wen0));
        step();
        cap0 = '0;
        cap1 = '0;
        for (int k = 0; k < BEATS; k++) begin
            cap0[k*B +: B] = o_wdata0;
            cap1[k*B +: B] = o_wdata1;
            checkOutput("wreq_once", 32'(o_wreq), 32'd0);
            checkOutput("wen0_beat", 32'(o_wen0), 32'(v.wen0));
            checkOutput("wen1_beat", 32'(o_wen1), 32'(v.wen1));
            checkOutput("busy_wshift", 32'(o_cmd_ready), 32'd0);
            checkOutput("no_rsp_early", 32'(o_rsp_valid), 32'd0);
            step();
        end
        checkOutput("wr_rsp_valid", 32'(o_rsp_valid), 32'd1);
        checkOutput("wen0_rsp_off", 32'(o_wen0), 32'd0);
        if (v.wen0) begin
            checkOutput("wdata0_serial", cap0, v.wdata0);
            rf_mem[v.reg0] = cap0;
        end
        if (v.wen1) begin
            checkOutput("wdata1_serial", cap1, v.wdata1);
            rf_mem[v.reg1] = cap1;
        end
        step();
        checkOutput("wr_rsp_end", 32'(o_rsp_valid), 32'd0);
        checkOutput("wr_ready_after", 32'(o_cmd_ready), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input bit hold);
        if (v.write) begin
            if (v.wen0) ref_mem[v.reg0] = v.wdata0;
            if (v.wen1) ref_mem[v.reg1] = v.wdata1;
            runWrite(v, hold);
        end else begin
            runRead(v, hold);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tbl [7];
        vec_t v;
        logic [31:0] word0;

        for (int i = 0; i < 64; i++) begin
            rf_mem[i]  = 32'h5A00_0000 | 32'(i);
            ref_mem[i] = 32'h5A00_0000 | 32'(i);
        end

        tbl[0] = mkVec(1, 5,  31, 1, 1, 32'hDEADBEEF, 32'h00000001, 0, 0, 0);
        tbl[1] = mkVec(0, 5,  31, 0, 0, 0, 0, 1, 32'hDEADBEEF, 32'h00000001);
        tbl[2] = mkVec(1, 7,  9,  1, 0, 32'h12345678, 32'hFFFFFFFF, 0, 0, 0);
        tbl[3] = mkVec(0, 7,  9,  0, 0, 0, 0, 0, 32'h12345678, 32'h5A000009);
        tbl[4] = mkVec(1, 32, 35, 1, 1, 32'hCAFEF00D, 32'h0BADC0DE, 0, 0, 0);
        tbl[5] = mkVec(0, 32, 35, 0, 0, 0, 0, 3, 32'hCAFEF00D, 32'h0BADC0DE);
        tbl[6] = mkVec(0, 35, 0,  0, 0, 0, 0, 0, 32'h0BADC0DE, 32'h5A000000);

        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0;
        i_cmd_reg0 = '0; i_cmd_reg1 = '0; i_cmd_wen0 = 1'b0; i_cmd_wen1 = 1'b0;
        i_cmd_wdata0 = '0; i_cmd_wdata1 = '0; rd_ready = 1'b0;
        i_rdata0 = '0; i_rdata1 = '0;
        step();
        step();
        checkOutput("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        checkOutput("rst_rreq", 32'(o_rreq), 32'd0);
        checkOutput("rst_wreq", 32'(o_wreq), 32'd0);
        checkOutput("rst_wen0", 32'(o_wen0), 32'd0);
        checkOutput("rst_wdata0", 32'(o_wdata0), 32'd0);
        checkOutput("rst_rdata0", o_rsp_rdata0, 32'd0);
        checkOutput("rst_rreg0", 32'(o_rreg0), 32'd0);
        i_rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            applyStimulus(tbl[i], 1'b0);

        // Back-to-back write then read of one register with valid held high.
        applyStimulus(mkVec(1, 12, 13, 1, 0, 32'hA5A5A5A5, 32'h0, 0, 0, 0), 1'b1);
        applyStimulus(mkVec(0, 12, 13, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 32'h5A00000D), 1'b0);

        // Reset in the middle of a read's beat phase.
        i_cmd_write = 1'b0; i_cmd_reg0 = 6'd5; i_cmd_reg1 = 6'd31; i_cmd_valid = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        step();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        word0 = rf_mem[5];
        for (int k = 0; k < 6; k++) begin
            i_rdata0 = word0[k*B +: B];
            i_rdata1 = 4'hF;
            if (k == 5) i_rst = 1'b1;
            step();
        end
        i_rst = 1'b0;
        checkOutput("midrst_idle", 32'(o_cmd_ready), 32'd1);
        checkOutput("midrst_rdata0", o_rsp_rdata0, 32'd0);
        for (int c = 0; c < 4; c++) begin
            checkOutput("midrst_no_rsp", 32'(o_rsp_valid), 32'd0);
            checkOutput("midrst_no_rreq", 32'(o_rreq), 32'd0);
            step();
        end
        applyStimulus(mkVec(0, 5, 31, 0, 0, 0, 0, 2, 32'hDEADBEEF, 32'h00000001), 1'b0);

        // Ready withheld for a long time.
        applyStimulus(mkVec(0, 32, 7, 0, 0, 0, 0, 50, 32'hCAFEF00D, 32'h12345678), 1'b0);

        for (int n = 0; n < 24; n++) begin
            v.write  = 1'($urandom);
            v.reg0   = RAW'($urandom_range(0, 35));
            v.reg1   = RAW'($urandom_range(0, 35));
            v.wen0   = 1'($urandom);
            v.wen1   = 1'($urandom);
            if (v.reg0 == v.reg1) v.wen1 = 1'b0;
            v.wdata0 = $urandom;
            v.wdata1 = $urandom;
            v.delay  = int'($urandom_range(0, 4));
            v.exp0   = ref_mem[v.reg0];
            v.exp1   = ref_mem[v.reg1];
            applyStimulus(v, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
